rv32i_stage_sequencer: RTL

// - Multi-cycle control FSM for the RV32I core: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK.
// - Drives the instruction/data bus handshakes and the writeback enable.
// - Enables the writeback block's PC and rd update for exactly one cycle per retired instruction.
// - Adds an ack-timeout watchdog and a halt path.

---
 rtl/rv32i_stage_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rv32i_stage_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_stage_sequencer
//  Purpose  : Multi-cycle control FSM for the RV32I core. Steps each
//             instruction through FETCH, DECODE, EXECUTE, optional MEMORY
//             and WRITEBACK, drives the instruction/data bus handshakes,
//             guards every bus wait with an ack-timeout watchdog and parks
//             the core in HALT on request or on a bus error.
//  Options  : RV32I_PERF_CNT_EN - adds cycle_cnt / instret_cnt counters.
//  Revision : 1.0 - initial release
// ============================================================================
module rv32i_stage_sequencer #(
    parameter int unsigned ACK_TIMEOUT = 16   // legal range 1..65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        halt,
    input  logic        i_ack,
    input  logic        d_ack,
    input  logic        opcode_load,
    input  logic        opcode_store,
    output logic        i_req,
    output logic        inst_we,
    output logic        d_req,
    output logic        d_we,
    output logic        writeback,
    output logic [2:0]  stage,
    output logic        halted,
    output logic        bus_err
`ifdef RV32I_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    // The wait counter holds the number of no-ack cycles already spent in the
    // current state, so the cycle on which it equals ACK_TIMEOUT-1 is the last
    // one a request may wait before the watchdog fires.
    localparam logic [15:0] c_WAIT_LIMIT = 16'(ACK_TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_wait;
    logic        w_wait_full;
    logic [15:0] w_wait_inc;

    assign w_wait_full = (r_wait >= c_WAIT_LIMIT);
    assign w_wait_inc  = (r_wait == 16'hFFFF) ? r_wait : (r_wait + 16'd1);

    // State, wait counter and bus-error pulse; the counter clears on any
    // state change and only advances in branches that stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wait  <= 16'd0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            r_wait  <= 16'd0;
            case (r_state)
                S_IDLE:    r_state <= S_FETCH;
                S_FETCH: begin
                    // An ack on the timeout cycle still wins.
                    if (i_ack) begin
                        r_state <= S_DECODE;
                    end else if (w_wait_full) begin
                        r_state <= S_HALT;
                        bus_err <= 1'b1;
                    end else begin
                        r_wait  <= w_wait_inc;
                    end
                end
                S_DECODE:  r_state <= S_EXECUTE;
                S_EXECUTE: begin
                    if (opcode_load || opcode_store) begin
                        r_state <= S_MEMORY;
                    end else begin
                        r_state <= S_WRITEBACK;
                    end
                end
                S_MEMORY: begin
                    // Timed-out memory access skips WRITEBACK entirely.
                    if (d_ack) begin
                        r_state <= S_WRITEBACK;
                    end else if (w_wait_full) begin
                        r_state <= S_HALT;
                        bus_err <= 1'b1;
                    end else begin
                        r_wait  <= w_wait_inc;
                    end
                end
                S_WRITEBACK: begin
                    if (halt) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (halt) begin
                        r_wait  <= w_wait_inc;
                    end else begin
                        r_state <= S_FETCH;
                    end
                end
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // Bus and commit strobes are pure decodes of the registered state.
    assign stage     = r_state;
    assign i_req     = (r_state == S_FETCH);
    assign inst_we   = (r_state == S_FETCH) & i_ack;
    assign d_req     = (r_state == S_MEMORY);
    assign d_we      = (r_state == S_MEMORY) & opcode_store;
    assign writeback = (r_state == S_WRITEBACK);
    assign halted    = (r_state == S_HALT);

`ifdef RV32I_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    // Active-cycle and retired-instruction counters; both wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            if (r_state != S_IDLE && r_state != S_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (r_state == S_WRITEBACK) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule
`default_nettype wire
